// File: rtl/loop_seeker.sv
// Bracket search controller: steps the IP counter to the matching loop bracket,
// tracking nesting depth in BCD for the indicator panel.
module loop_seeker #(
    parameter int                  OP_WIDTH      = 4,
    parameter logic [OP_WIDTH-1:0] OP_LOOP_BEGIN = 4'h6,
    parameter logic [OP_WIDTH-1:0] OP_LOOP_END   = 4'h7,
    parameter logic [OP_WIDTH-1:0] OP_HALT       = 4'hF,
    parameter int                  DEPTH_DIGITS  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      seek,
    input  logic                      dir,
    input  logic [OP_WIDTH-1:0]       instr,
    output logic                      ip_step,
    output logic                      ip_reverse,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [4*DEPTH_DIGITS-1:0] depth
);

    localparam int DW = 4 * DEPTH_DIGITS;

    typedef enum logic [1:0] {IDLE, STEP, CHECK, FINISH} state_t;

    state_t          state_reg, state_next;
    logic            ip_reverse_reg, ip_reverse_next;
    logic [DW-1:0]   depth_reg, depth_next;
    logic            error_reg, error_next;
    logic            armed_reg;

    logic [DW-1:0]         depth_inc, depth_dec;
    logic [DEPTH_DIGITS:0] inc_carry;
    logic [DEPTH_DIGITS:0] dec_borrow;
    logic                  depth_zero;
    logic                  depth_full;

    // Ripple BCD increment/decrement, one digit per generate iteration.
    assign inc_carry[0]  = 1'b1;
    assign dec_borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DEPTH_DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit = depth_reg[gi*4 +: 4];
            assign depth_inc[gi*4 +: 4] = !inc_carry[gi] ? digit :
                                          (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            assign depth_dec[gi*4 +: 4] = !dec_borrow[gi] ? digit :
                                          (digit == 4'd0) ? 4'd9 : digit - 4'd1;
            assign inc_carry[gi+1]  = inc_carry[gi] && (digit == 4'd9);
            assign dec_borrow[gi+1] = dec_borrow[gi] && (digit == 4'd0);
        end
    endgenerate

    assign depth_zero = dec_borrow[DEPTH_DIGITS];
    assign depth_full = inc_carry[DEPTH_DIGITS];

    // Bracket roles swap with direction: "open" nests deeper, "close" unwinds.
    logic [OP_WIDTH-1:0] open_op, close_op;
    assign open_op  = ip_reverse_reg ? OP_LOOP_END   : OP_LOOP_BEGIN;
    assign close_op = ip_reverse_reg ? OP_LOOP_BEGIN : OP_LOOP_END;

    always_comb begin
        state_next      = state_reg;
        ip_reverse_next = ip_reverse_reg;
        depth_next      = depth_reg;
        error_next      = error_reg;
        case (state_reg)
            IDLE: begin
                if (seek && armed_reg) begin
                    ip_reverse_next = dir;
                    depth_next      = '0;
                    error_next      = 1'b0;
                    state_next      = STEP;
                end
            end
            STEP: state_next = CHECK;
            CHECK: begin
                state_next = STEP;
                if (instr == close_op) begin
                    if (depth_zero) begin
                        state_next = FINISH;
                    end else begin
                        depth_next = depth_dec;
                    end
                end else if (instr == open_op) begin
                    if (depth_full) begin
                        state_next = FINISH;
                        error_next = 1'b1;
                    end else begin
                        depth_next = depth_inc;
                    end
                end else if (instr == OP_HALT) begin
                    state_next = FINISH;
                    error_next = 1'b1;
                end
            end
            FINISH: begin
                state_next      = IDLE;
                ip_reverse_next = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    // armed_reg blocks a seek presented in the same cycle reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ip_reverse_reg <= 1'b0;
            depth_reg      <= '0;
            error_reg      <= 1'b0;
            armed_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ip_reverse_reg <= ip_reverse_next;
            depth_reg      <= depth_next;
            error_reg      <= error_next;
            armed_reg      <= 1'b1;
        end
    end

    assign ip_step    = (state_reg == STEP);
    assign busy       = (state_reg == STEP) || (state_reg == CHECK);
    assign done       = (state_reg == FINISH);
    assign ip_reverse = ip_reverse_reg;
    assign error      = error_reg;
    assign depth      = depth_reg;

endmodule

// File: tb/tb_loop_seeker.sv
// Directed bench for loop_seeker with a behavioural IP counter and program memory.
module tb_loop_seeker;

    localparam logic [3:0] LB = 4'h6;
    localparam logic [3:0] LE = 4'h7;
    localparam logic [3:0] HT = 4'hF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       seek = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] instr;
    logic       ip_step, ip_reverse, busy, done, error;
    logic [7:0] depth;

    logic [3:0] prog [256];
    int         ip = 0;
    logic       load_en = 1'b0;
    int         load_val = 0;

    int checks = 0;
    int errors = 0;

    int         done_cyc, steps;
    logic       b2b, rev_bad, err_c1, err_done;
    logic [7:0] depth_done;
    logic [7:0] trace [$];

    loop_seeker dut (
        .clk(clk), .rst_n(rst_n), .seek(seek), .dir(dir), .instr(instr),
        .ip_step(ip_step), .ip_reverse(ip_reverse), .busy(busy),
        .done(done), .error(error), .depth(depth)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en)      ip <= load_val;
        else if (ip_step) ip <= ip_reverse ? ip - 1 : ip + 1;
    end

    assign instr = prog[ip[7:0]];

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = HT;
    endtask

    // "[ + [ - ] > ]"
    task automatic load_nested();
        clear_prog();
        prog[0] = LB; prog[1] = 4'h1; prog[2] = LB; prog[3] = 4'h2;
        prog[4] = LE; prog[5] = 4'h3; prog[6] = LE;
    endtask

    task automatic run_seek(input int start_ip, input logic d, input int budget, input int repulse);
        @(posedge clk); #1;
        load_val = start_ip; load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0; seek = 1'b1; dir = d;
        done_cyc = -1; steps = 0; b2b = 0; rev_bad = 0; err_c1 = 1'bx;
        err_done = 1'bx; depth_done = 8'hxx; trace.delete();
        for (int c = 1; c <= budget; c++) begin
            logic prev;
            prev = (c == 1) ? 1'b0 : ip_step;
            @(posedge clk); #1;
            seek = (c == repulse);
            if (ip_step) begin
                steps++;
                if (prev) b2b = 1;
                if (ip_reverse !== d) rev_bad = 1;
            end
            if (c == 1) err_c1 = error;
            if (trace.size() == 0 || trace[$] !== depth) trace.push_back(depth);
            if (done) begin
                done_cyc = c; err_done = error; depth_done = depth;
                break;
            end
        end
        seek = 1'b0;
        $display("seek start=%0d dir=%0d done_cycle=%0d steps=%0d ip=%0d error=%0b depth=%h",
                 start_ip, d, done_cyc, steps, ip, err_done, depth_done);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({ip_step, ip_reverse, busy, done, error, depth} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {ip_step, ip_reverse, busy, done, error, depth});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_forward_adjacent();
        clear_prog(); prog[0] = LB; prog[1] = LE;
        run_seek(0, 1'b0, 20, 0);
        checks++; if (done_cyc !== 3) begin errors++; $display("FAIL adj_done_cycle: got %0d expected 3", done_cyc); end
        checks++; if (err_done !== 1'b0) begin errors++; $display("FAIL adj_error: got %b expected 0", err_done); end
        checks++; if (depth_done !== 8'h00) begin errors++; $display("FAIL adj_depth: got %h expected 00", depth_done); end
        checks++; if (ip !== 1) begin errors++; $display("FAIL adj_ip: got %0d expected 1", ip); end
        checks++; if (steps !== 1) begin errors++; $display("FAIL adj_steps: got %0d expected 1", steps); end
        checks++; if (rev_bad !== 1'b0) begin errors++; $display("FAIL adj_reverse: got %b expected 0", rev_bad); end
    endtask

    task automatic test_forward_nested();
        load_nested();
        run_seek(0, 1'b0, 40, 0);
        checks++; if (done_cyc !== 13) begin errors++; $display("FAIL fwd_done_cycle: got %0d expected 13", done_cyc); end
        checks++; if (ip !== 6) begin errors++; $display("FAIL fwd_ip: got %0d expected 6", ip); end
        checks++; if (steps !== 6) begin errors++; $display("FAIL fwd_steps: got %0d expected 6", steps); end
        checks++; if (b2b !== 1'b0) begin errors++; $display("FAIL fwd_back_to_back: got %b expected 0", b2b); end
        checks++;
        if (trace.size() != 3 || trace[0] !== 8'h00 || trace[1] !== 8'h01 || trace[2] !== 8'h00) begin
            errors++;
            $display("FAIL fwd_depth_trace: got size %0d expected 00,01,00", trace.size());
        end
        checks++; if (err_done !== 1'b0) begin errors++; $display("FAIL fwd_error: got %b expected 0", err_done); end
    endtask

    task automatic test_reverse_nested();
        load_nested();
        run_seek(6, 1'b1, 40, 0);
        checks++; if (done_cyc !== 13) begin errors++; $display("FAIL rev_done_cycle: got %0d expected 13", done_cyc); end
        checks++; if (ip !== 0) begin errors++; $display("FAIL rev_ip: got %0d expected 0", ip); end
        checks++; if (steps !== 6) begin errors++; $display("FAIL rev_steps: got %0d expected 6", steps); end
        checks++; if (rev_bad !== 1'b0) begin errors++; $display("FAIL rev_direction: got %b expected 0", rev_bad); end
        checks++; if (depth_done !== 8'h00) begin errors++; $display("FAIL rev_depth: got %h expected 00", depth_done); end
        checks++; if (err_done !== 1'b0) begin errors++; $display("FAIL rev_error: got %b expected 0", err_done); end
        @(posedge clk); #1;
        checks++; if (ip_reverse !== 1'b0) begin errors++; $display("FAIL rev_idle_dir: got %b expected 0", ip_reverse); end
    endtask

    task automatic test_unmatched();
        clear_prog(); prog[0] = LB; prog[1] = 4'h1; prog[2] = 4'h1;
        run_seek(0, 1'b0, 30, 0);
        checks++; if (done_cyc !== 7) begin errors++; $display("FAIL unm_done_cycle: got %0d expected 7", done_cyc); end
        checks++; if (err_done !== 1'b1) begin errors++; $display("FAIL unm_error: got %b expected 1", err_done); end
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({error, done, busy} !== 3'b100) begin
            errors++; $display("FAIL unm_error_hold: got %b expected 100", {error, done, busy});
        end
        clear_prog(); prog[0] = LB; prog[1] = LE;
        run_seek(0, 1'b0, 20, 0);
        checks++; if (err_c1 !== 1'b0) begin errors++; $display("FAIL unm_error_clear: got %b expected 0", err_c1); end
        checks++; if (err_done !== 1'b0) begin errors++; $display("FAIL unm_next_error: got %b expected 0", err_done); end
    endtask

    task automatic test_depth_overflow();
        clear_prog();
        for (int i = 0; i <= 100; i++) prog[i] = LB;
        prog[101] = LE;
        run_seek(0, 1'b0, 250, 0);
        checks++; if (done_cyc !== 201) begin errors++; $display("FAIL ovf_done_cycle: got %0d expected 201", done_cyc); end
        checks++; if (err_done !== 1'b1) begin errors++; $display("FAIL ovf_error: got %b expected 1", err_done); end
        checks++; if (depth_done !== 8'h99) begin errors++; $display("FAIL ovf_depth: got %h expected 99", depth_done); end
        checks++; if (ip !== 100) begin errors++; $display("FAIL ovf_ip: got %0d expected 100", ip); end
        checks++;
        if (trace.size() != 100 || trace[9] !== 8'h09 || trace[10] !== 8'h10 ||
            trace[98] !== 8'h98 || trace[99] !== 8'h99) begin
            errors++; $display("FAIL ovf_bcd_trace: got size %0d expected 100 BCD steps 00..99", trace.size());
        end
    endtask

    task automatic test_seek_while_busy();
        load_nested();
        run_seek(0, 1'b0, 40, 2);
        checks++; if (done_cyc !== 13) begin errors++; $display("FAIL busy_done_cycle: got %0d expected 13", done_cyc); end
        checks++; if (steps !== 6) begin errors++; $display("FAIL busy_steps: got %0d expected 6", steps); end
        repeat (3) @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_search();
        load_nested();
        @(posedge clk); #1 load_val = 0; load_en = 1'b1;
        @(posedge clk); #1 load_en = 1'b0; seek = 1'b1; dir = 1'b0;
        @(posedge clk); #1 seek = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({ip_step, depth} !== {1'b1, 8'h01}) begin
            errors++; $display("FAIL rst_precondition: got step=%b depth=%h expected step=1 depth=01", ip_step, depth);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ip_step, busy, done, error, depth} !== 12'd0) begin
            errors++; $display("FAIL rst_async: got %b expected all zero", {ip_step, busy, done, error, depth});
        end
        @(posedge clk); #1;
        rst_n = 1'b1; seek = 1'b1; dir = 1'b0;
        @(posedge clk); #1 seek = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_seek: got busy=%b expected 0", busy); end
        $display("reset mid-search: ip left at %0d", ip);
        run_seek(2, 1'b0, 20, 0);
        checks++; if (done_cyc !== 5) begin errors++; $display("FAIL rst_fresh_done: got %0d expected 5", done_cyc); end
        checks++; if (ip !== 4) begin errors++; $display("FAIL rst_fresh_ip: got %0d expected 4", ip); end
        checks++; if (err_done !== 1'b0) begin errors++; $display("FAIL rst_fresh_error: got %b expected 0", err_done); end
    endtask

    initial begin
        clear_prog();
        test_reset();
        test_forward_adjacent();
        test_forward_nested();
        test_reverse_nested();
        test_unmatched();
        test_depth_overflow();
        test_seek_while_busy();
        test_reset_mid_search();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/loop_seeker.md
Name: loop_seeker

Overview:
- Control stage directly upstream of the IP counter.
- When the execution unit hits an untaken loop bracket, this block steps the IP counter forward or backward one instruction at a time until it reaches the matching bracket.
- It reads the opcode at the current IP from program memory and tracks nesting depth in a BCD counter, so the depth can be shown on the dekatron/indicator panel.
- It owns the IP counter's step enable and direction lines for the whole search.

Parameters:
- OP_WIDTH, 4, opcode width in bits.
- OP_LOOP_BEGIN, 4'h6, opcode of "[".
- OP_LOOP_END, 4'h7, opcode of "]".
- OP_HALT, 4'hF, end-of-program opcode; reaching it during a search means the brackets are unmatched.
- DEPTH_DIGITS, 2, number of BCD digits in the nesting depth counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Seek  in  1  single-cycle start request; sampled only in IDLE.
- Dir  in  1  search direction, sampled with Seek: 0 = forward (from "[" find "]"), 1 = reverse (from "]" find "[").
- Instr  in  OP_WIDTH  opcode at the current IP; valid one cycle after any IpStep pulse.
- IpStep  out  1  one-cycle step enable to the IP counter.
- IpReverse  out  1  direction to the IP counter; 1 = decrement.
- Busy  out  1  search in progress.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  sticky fault flag, valid with Done.
- Depth  out  4*DEPTH_DIGITS  current nesting depth in BCD.

Behaviour:
- Reset (asynchronous, any state, including mid-search):
  - FSM goes to IDLE.
  - IpStep=0, IpReverse=0, Busy=0, Done=0, Error=0, Depth=0.
  - A search interrupted by reset is abandoned; the IP is left wherever it stopped.
- FSM states: IDLE, STEP, CHECK, FINISH.
- IDLE:
  - Seek=1 latches Dir into IpReverse, clears Depth and Error, and moves to STEP.
  - Seek with Busy=1 cannot occur: Seek is ignored outside IDLE.
- STEP:
  - IpStep=1 for exactly this cycle; IpReverse is stable.
  - Next state is CHECK.
- CHECK (samples Instr, the opcode one step on from the previous IP):
  - Found: forward search with Instr==OP_LOOP_END and Depth==0, or reverse search with Instr==OP_LOOP_BEGIN and Depth==0. Go to FINISH, Error=0.
  - Same-type bracket (OP_LOOP_BEGIN forward, OP_LOOP_END reverse): Depth += 1 in BCD, then go to STEP.
  - Opposite bracket with Depth>0: Depth -= 1 in BCD, then go to STEP.
  - Instr==OP_HALT: go to FINISH, Error=1 (unmatched bracket).
  - Any other opcode: go to STEP.
- Depth arithmetic:
  - Per-digit BCD increment with carry (09 -> 10, 99 overflows).
  - Decrement with borrow (10 -> 09).
  - Increment at the all-nines value (99 for 2 digits) goes to FINISH with Error=1; Depth holds 99 (no wrap).
- FINISH:
  - Done=1 for one cycle; Busy=0 in this cycle.
  - Next state is IDLE.
  - IpReverse returns to 0 on entry to IDLE.
- Busy is 1 in STEP and CHECK only.
- IP ends on the matching bracket, not past it; stepping past it is the caller's job.
- Timing:
  - Each instruction visited costs 2 cycles.
  - A match k instructions away gives Done at cycle 2k+1 after the Seek cycle.
  - IpStep never asserts twice in consecutive cycles.
- Error and Depth hold their values after Done until the next accepted Seek or reset.
- Reverse search with the IP reaching 000000: the IP counter wraps (999999) and the search continues. No special case; program memory holds OP_HALT above the program.
- Seek arriving in the same cycle as Rst_n deassertion is ignored.

Test Plan:
1. Forward, adjacent: program "[ ]", IP at "[", Seek=1, Dir=0 -> IpStep at cycle 1, Done at cycle 3, Error=0, Depth=00, IP advanced by 1, IpReverse=0 throughout.
2. Forward, nested: "[ + [ - ] > ]", IP at index 0 -> Depth sequence 00,01,00; Done at cycle 13 (k=6); IP=6; exactly 6 IpStep pulses, none back-to-back.
3. Reverse, nested: same program, IP at index 6, Dir=1 -> IpReverse=1 with every IpStep; Done with IP=0, Depth=00, Error=0, 6 pulses.
4. Unmatched: "[ + +" then OP_HALT at index 3, forward seek -> Done at cycle 7 with Error=1; Error holds until the next Seek clears it.
5. Depth overflow/BCD: 100 consecutive "[" after the start bracket, forward seek -> Depth passes 09->10 and 98->99; the 100th "[" gives Done with Error=1 and Depth=99.
6. Reset mid-search and Seek-while-busy: Seek pulse during CHECK is ignored (no restart, step count unchanged); Rst_n low during STEP -> IpStep, Busy, Depth=0 immediately (asynchronous); after release, a fresh Seek completes normally.
